uart_rx_mode3: RTL and testbench

UART_RX_MODE3 -- requirements
Module: uart_rx_mode3

---
 rtl/uart_rx_mode3.sv | 173 +++++++++++++++++
 tb/tb_uart_rx_mode3.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_mode3.sv
// uart_rx_mode3: 9-bit (mode 3 style) UART receiver.
// 2-flop input synchronizer, 3-sample majority vote around mid-bit,
// multiprocessor (sm2) address filtering, sticky ri flag with overrun and
// framing-error pulses. The stop bit is resolved at mid-bit so that
// back-to-back frames are received without losing the next start edge.
module uart_rx_mode3 #(
  parameter int CLK_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ren,
  input  logic       sm2,
  input  logic       ri_clr,
  output logic [7:0] rx_data,
  output logic       rb8,
  output logic       ri,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int H  = CLK_PER_BIT / 2;

  localparam logic [CW-1:0] CNT_HM1  = CW'(H - 1);
  localparam logic [CW-1:0] CNT_H    = CW'(H);
  localparam logic [CW-1:0] CNT_HP1  = CW'(H + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;

  logic          rx_p0;
  logic          rx_p1;
  logic          rx_prev;
  logic          rxs;

  logic          smp_a;
  logic          smp_b;
  logic [8:0]    shreg;

  logic          fall;
  logic          bit_val;
  logic          bit_end;
  logic          at_resolve;
  logic          ri_eff;
  logic          sm2_pass;

  // 2-of-3 majority of the samples taken at H-1, H and H+1.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign rxs        = rx_p1;
  assign fall       = rx_prev & ~rxs;
  assign at_resolve = (cnt == CNT_HP1);
  assign bit_end    = (cnt == CNT_LAST);
  assign bit_val    = majority3(smp_a, smp_b, rxs);
  assign ri_eff     = ri & ~ri_clr;
  assign sm2_pass   = ~sm2 | shreg[8];
  assign rx_busy    = (state != IDLE);

  // Stage p0/p1: metastability synchronizer plus previous sample for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_p0   <= 1'b1;
      rx_p1   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_p0   <= rx;
      rx_p1   <= rx_p0;
      rx_prev <= rx_p1;
    end
  end

  // Sample capture and bit shifting; pure datapath, no reset needed.
  always_ff @(posedge clk) begin
    if (cnt == CNT_HM1) smp_a <= rxs;
    if (cnt == CNT_H)   smp_b <= rxs;
    if (state == DATA && at_resolve) shreg <= {bit_val, shreg[8:1]};
  end

  // Receiver FSM with bit timing, frame evaluation and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      rx_data   <= 8'h00;
      rb8       <= 1'b0;
      ri        <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A load later in this block takes precedence over the clear.
      if (ri_clr) ri <= 1'b0;

      if (!ren) begin
        state   <= IDLE;
        cnt     <= '0;
        bit_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt     <= '0;
            bit_idx <= '0;
            if (fall) state <= START;
          end

          START: begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
            if (at_resolve && bit_val) begin
              // Line was high at mid-bit: glitch, not a start bit.
              state <= IDLE;
              cnt   <= '0;
            end else if (bit_end) begin
              state   <= DATA;
              bit_idx <= '0;
            end
          end

          DATA: begin
            cnt <= bit_end ? '0 : cnt + 1'b1;
            if (bit_end) begin
              if (bit_idx == 4'd8) begin
                state   <= STOP;
                bit_idx <= '0;
              end else begin
                bit_idx <= bit_idx + 4'd1;
              end
            end
          end

          STOP: begin
            cnt <= cnt + 1'b1;
            if (at_resolve) begin
              state <= IDLE;
              cnt   <= '0;
              if (!bit_val) begin
                frame_err <= 1'b1;
              end else if (sm2_pass) begin
                if (!ri_eff) begin
                  rx_data <= shreg[7:0];
                  rb8     <= shreg[8];
                  ri      <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_mode3.sv
// Directed testbench for uart_rx_mode3 at CLK_PER_BIT = 16.
module tb_uart_rx_mode3;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ren;
  logic       sm2;
  logic       ri_clr;
  logic [7:0] rx_data;
  logic       rb8;
  logic       ri;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int fe_cnt;
  int ov_cnt;
  logic busy_mid;

  uart_rx_mode3 #(.CLK_PER_BIT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .ren       (ren),
    .sm2       (sm2),
    .ri_clr    (ri_clr),
    .rx_data   (rx_data),
    .rb8       (rb8),
    .ri        (ri),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one 11-bit frame (start, 8 data LSB first, bit8, stop), 16 clocks
  // per bit. The start edge lands in START with cnt=0 three edges after rx
  // falls, so the stop bit is resolved on edge 173 counted from frame start;
  // clr_stop drives ri_clr high for exactly the cycle sampled on that edge.
  task automatic send_frame(input logic [7:0] d, input logic b8, input logic stp,
                            input logic clr_stop);
    logic [10:0] bits;
    bits = {stp, b8, d, 1'b0};
    fe_cnt   = 0;
    ov_cnt   = 0;
    busy_mid = 1'b0;
    for (int i = 0; i < 176; i++) begin
      rx = bits[i / 16];
      ri_clr = clr_stop && (i == 172);
      tick();
      fe_cnt += int'(frame_err);
      ov_cnt += int'(overrun);
      if (i == 20) busy_mid = rx_busy;
    end
    rx = 1'b1;
    ri_clr = 1'b0;
  endtask

  task automatic pulse_ri_clr();
    ri_clr = 1'b1;
    tick();
    ri_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; ren = 1'b1; sm2 = 1'b0; ri_clr = 1'b0;
    repeat (3) tick();
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    checks++; if ({rb8, ri, frame_err, overrun} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {rb8, ri, frame_err, overrun}); end
    rst = 1'b0;
    repeat (5) tick();
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_release_no_start: got %b expected 0", rx_busy); end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL basic_busy_mid: got %b expected 1", busy_mid); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", rx_busy); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", rx_data); end
    checks++; if (rb8 !== 1'b0) begin errors++; $display("FAIL basic_rb8: got %b expected 0", rb8); end
    checks++; if (ri !== 1'b1) begin errors++; $display("FAIL basic_ri: got %b expected 1", ri); end
    checks++; if (fe_cnt != 0 || ov_cnt != 0) begin errors++; $display("FAIL basic_flags: got fe=%0d ov=%0d expected 0 0", fe_cnt, ov_cnt); end
    pulse_ri_clr();
    checks++; if (ri !== 1'b0) begin errors++; $display("FAIL ri_clear: got %b expected 0", ri); end
  endtask

  task automatic test_sm2();
    sm2 = 1'b1;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    checks++; if (ri !== 1'b0) begin errors++; $display("FAIL sm2_drop_ri: got %b expected 0", ri); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL sm2_drop_data: got %h expected a5", rx_data); end
    checks++; if (ov_cnt != 0) begin errors++; $display("FAIL sm2_drop_ov: got %0d expected 0", ov_cnt); end
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL sm2_accept_data: got %h expected 3c", rx_data); end
    checks++; if (rb8 !== 1'b1) begin errors++; $display("FAIL sm2_accept_rb8: got %b expected 1", rb8); end
    checks++; if (ri !== 1'b1) begin errors++; $display("FAIL sm2_accept_ri: got %b expected 1", ri); end
    sm2 = 1'b0;
  endtask

  // ri is still 1 from the sm2 test; both frames are sent back to back.
  task automatic test_back_to_back();
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    checks++; if (ov_cnt != 1) begin errors++; $display("FAIL overrun_pulse: got %0d cycles expected 1", ov_cnt); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL overrun_data: got %h expected 3c", rx_data); end
    checks++; if (ri !== 1'b1) begin errors++; $display("FAIL overrun_ri: got %b expected 1", ri); end
    send_frame(8'h55, 1'b0, 1'b1, 1'b1);
    checks++; if (ov_cnt != 0) begin errors++; $display("FAIL clr_load_ov: got %0d expected 0", ov_cnt); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL clr_load_data: got %h expected 55", rx_data); end
    checks++; if (ri !== 1'b1) begin errors++; $display("FAIL clr_load_ri: got %b expected 1", ri); end
    checks++; if (rb8 !== 1'b0) begin errors++; $display("FAIL clr_load_rb8: got %b expected 0", rb8); end
  endtask

  task automatic test_false_start();
    pulse_ri_clr();
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    tick();
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL false_start_busy: got %b expected 1", rx_busy); end
    repeat (20) tick();
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL false_start_idle: got %b expected 0", rx_busy); end
    checks++; if (ri !== 1'b0) begin errors++; $display("FAIL false_start_ri: got %b expected 0", ri); end
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL after_false_data: got %h expected 81", rx_data); end
    checks++; if (ri !== 1'b1) begin errors++; $display("FAIL after_false_ri: got %b expected 1", ri); end
  endtask

  task automatic test_frame_err();
    pulse_ri_clr();
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    checks++; if (fe_cnt != 1) begin errors++; $display("FAIL frame_err_pulse: got %0d cycles expected 1", fe_cnt); end
    checks++; if (ri !== 1'b0) begin errors++; $display("FAIL frame_err_ri: got %b expected 0", ri); end
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL frame_err_data: got %h expected 81", rx_data); end
  endtask

  task automatic test_ren_abort();
    logic [10:0] bits;
    bits = {1'b1, 1'b0, 8'h99, 1'b0};
    for (int i = 0; i < 40; i++) begin
      rx = bits[i / 16];
      tick();
    end
    ren = 1'b0;
    rx = 1'b1;
    tick();
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ren_abort_busy: got %b expected 0", rx_busy); end
    ren = 1'b1;
    repeat (200) tick();
    checks++; if (ri !== 1'b0 || rx_data !== 8'h81) begin errors++; $display("FAIL ren_abort_state: got ri=%b data=%h expected ri=0 data=81", ri, rx_data); end
  endtask

  // Reset asserted while data bit 4 is being received (edge 89 of the frame).
  task automatic test_reset_mid();
    logic [10:0] bits;
    send_frame(8'h42, 1'b1, 1'b1, 1'b0);
    bits = {1'b1, 1'b0, 8'hFF, 1'b0};
    for (int i = 0; i < 88; i++) begin
      rx = bits[i / 16];
      tick();
    end
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL reset_mid_busy_before: got %b expected 1", rx_busy); end
    rst = 1'b1;
    rx = 1'b1;
    tick();
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b expected 0", rx_busy); end
    checks++; if ({rx_data, rb8, ri} !== 10'b0) begin errors++; $display("FAIL reset_mid_outputs: got data=%h rb8=%b ri=%b expected 00 0 0", rx_data, rb8, ri); end
    rst = 1'b0;
    repeat (200) tick();
    checks++; if (ri !== 1'b0) begin errors++; $display("FAIL reset_mid_no_load: got %b expected 0", ri); end
    send_frame(8'h12, 1'b0, 1'b1, 1'b0);
    checks++; if (rx_data !== 8'h12 || ri !== 1'b1) begin errors++; $display("FAIL after_reset_frame: got data=%h ri=%b expected 12 1", rx_data, ri); end
    checks++; if (fe_cnt != 0 || ov_cnt != 0) begin errors++; $display("FAIL after_reset_flags: got fe=%0d ov=%0d expected 0 0", fe_cnt, ov_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sm2();
    test_back_to_back();
    test_false_start();
    test_frame_err();
    test_ren_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
